// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: instruction sequencer for the 8-bit accumulator datapath.
// Fetches 16-bit instructions from a synchronous ROM, drives the external
// combinational ALU, and owns the accumulator, PC, flags and output register.
// Optional feature macro: ACC_SEQ_CTRL_DIVZ_TRAP_EN
//   defined   -> DIV by zero raises a sticky trap and halts
//   undefined -> DIV by zero saturates the accumulator and continues
module acc_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [7:0]  alu_result,
    input  logic        alu_ovr,
    input  logic        alu_zero,
    output logic [7:0]  acc,
    output logic        flag_z,
    output logic        flag_v,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        halted,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_OUTW
    } state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_JNZ  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_JZ   = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [7:0]  imm;
    logic        unused_ir_bits;

    assign op             = ir[15:12];
    assign imm            = ir[7:0];
    assign unused_ir_bits = ^ir[11:8];

    assign rom_addr = pc;
    assign alu_a    = acc;
    assign alu_b    = imm;

    function automatic logic is_alu_op(input logic [3:0] code);
        return (code == OP_AND) || (code == OP_OR)  || (code == OP_ADD) ||
               (code == OP_SUB) || (code == OP_MUL) || (code == OP_DIV) ||
               (code == OP_SLT) || (code == OP_NOR);
    endfunction

`ifdef ACC_SEQ_CTRL_DIVZ_TRAP_EN
    logic trap_q;
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Sequencer FSM: owns all architectural state and registered outputs.
    // alu_ctrl is registered from rom_data in DECODE so it is valid for the
    // whole EXEC cycle and zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HALT;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            alu_ctrl  <= '0;
            halted    <= 1'b1;
`ifdef ACC_SEQ_CTRL_DIVZ_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_HALT: begin
`ifdef ACC_SEQ_CTRL_DIVZ_TRAP_EN
                    if (run && !trap_q) begin
`else
                    if (run) begin
`endif
                        state  <= S_FETCH;
                        halted <= 1'b0;
                    end
                end

                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    ir       <= rom_data;
                    alu_ctrl <= is_alu_op(rom_data[15:12]) ? rom_data[15:12] : 4'b0000;
                    state    <= S_EXEC;
                end

                S_EXEC: begin
                    alu_ctrl <= '0;
                    state    <= S_FETCH;
                    pc       <= pc + 8'd1;
                    if (is_alu_op(op)) begin
                        if ((op == OP_DIV) && (imm == 8'h00)) begin
`ifdef ACC_SEQ_CTRL_DIVZ_TRAP_EN
                            trap_q <= 1'b1;
                            state  <= S_HALT;
                            halted <= 1'b1;
`else
                            acc    <= 8'hFF;
                            flag_v <= 1'b1;
                            flag_z <= 1'b0;
`endif
                        end else begin
                            acc    <= alu_result;
                            flag_z <= alu_zero;
                            flag_v <= alu_ovr;
                        end
                    end else begin
                        case (op)
                            OP_LDI: acc <= imm;
                            OP_JMP: pc  <= imm;
                            OP_JZ:  if (flag_z)  pc <= imm;
                            OP_JNZ: if (!flag_z) pc <= imm;
                            OP_OUT: begin
                                out_data  <= acc;
                                out_valid <= 1'b1;
                                state     <= S_OUTW;
                            end
                            OP_HALT: begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                S_OUTW: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_FETCH;
                    end
                end

                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed testbench for acc_seq_ctrl with a behavioural ROM and ALU.
module tb_acc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_result;
    logic        alu_ovr;
    logic        alu_zero;
    logic [7:0]  acc;
    logic        flag_z;
    logic        flag_v;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        halted;
    logic        trap;

    int tests = 0;
    int fails = 0;

    logic [15:0] rom [256];

    always #5 clk = ~clk;

    acc_seq_ctrl dut (
        .clk(clk), .rst(rst), .run(run),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_ovr(alu_ovr), .alu_zero(alu_zero),
        .acc(acc), .flag_z(flag_z), .flag_v(flag_v),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted), .trap(trap)
    );

    // Synchronous ROM: data appears the cycle after the address is sampled.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Reference ALU; DIV by zero deliberately yields 0/zero so saturation must come from the DUT.
    always_comb begin
        logic [8:0]  w;
        logic [15:0] m;
        w = '0;
        m = '0;
        case (alu_ctrl)
            4'b0000: w = {1'b0, alu_a & alu_b};
            4'b0001: w = {1'b0, alu_a | alu_b};
            4'b0010: w = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0011: w = {1'b0, alu_a} - {1'b0, alu_b};
            4'b0100: begin m = alu_a * alu_b; w = m[8:0]; end
            4'b0101: w = (alu_b == 8'h00) ? 9'h000 : {1'b0, alu_a / alu_b};
            4'b0111: w = (alu_a < alu_b) ? 9'h001 : 9'h000;
            4'b1100: w = {1'b0, ~(alu_a | alu_b)};
            default: w = '0;
        endcase
        alu_result = w[7:0];
        alu_ovr    = w[8];
        alu_zero   = (w[7:0] == 8'h00);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'hE000;
        rom[8'h00] = 16'h8005;  // LDI 5
        rom[8'h01] = 16'h2003;  // ADD 3
        rom[8'h02] = 16'h3008;  // SUB 8
        rom[8'h03] = 16'hA010;  // JZ 0x10
        rom[8'h10] = 16'h80C8;  // LDI 200
        rom[8'h11] = 16'h2064;  // ADD 100
        rom[8'h12] = 16'h8080;  // LDI 0x80
        rom[8'h13] = 16'h4002;  // MUL 2
        rom[8'h14] = 16'h6030;  // JNZ 0x30 (not taken)
        rom[8'h15] = 16'h805A;  // LDI 0x5A
        rom[8'h16] = 16'hD000;  // OUT
        rom[8'h17] = 16'h9007;  // JMP 0x07
        rom[8'h07] = 16'hF000;  // HALT
        rom[8'h08] = 16'h8009;  // LDI 9
        rom[8'h09] = 16'h5000;  // DIV 0
        rom[8'h0A] = 16'h90FF;  // JMP 0xFF
        rom[8'hFF] = 16'hE000;  // NOP

        rst = 1'b1; run = 1'b0; out_ready = 1'b0;
        steps(2);
        check("rst_halted", {15'd0, halted}, 16'd1);
        check("rst_pc", {8'd0, rom_addr}, 16'h00);
        check("rst_acc", {8'd0, acc}, 16'h00);
        check("rst_flags", {14'd0, flag_z, flag_v}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_trap", {15'd0, trap}, 16'd0);
        rst = 1'b0;
        step();
        check("halt_without_run", {15'd0, halted}, 16'd1);

        // ALU chain and taken JZ
        run = 1'b1;
        step();
        run = 1'b0;
        check("fetch0_halted", {15'd0, halted}, 16'd0);
        check("fetch0_addr", {8'd0, rom_addr}, 16'h00);
        steps(3);
        check("ldi5_acc", {8'd0, acc}, 16'h05);
        check("ldi5_pc", {8'd0, rom_addr}, 16'h01);
        steps(2);
        check("add_exec_ctrl", {12'd0, alu_ctrl}, 16'h2);
        check("add_exec_b", {8'd0, alu_b}, 16'h03);
        step();
        check("add_acc", {8'd0, acc}, 16'h08);
        check("add_ctrl_idle", {12'd0, alu_ctrl}, 16'h0);
        steps(3);
        check("sub_acc", {8'd0, acc}, 16'h00);
        check("sub_flags_zv", {14'd0, flag_z, flag_v}, 16'b10);
        steps(3);
        check("jz_taken_addr", {8'd0, rom_addr}, 16'h10);

        // Overflow cases
        steps(3);
        check("ldi200_acc", {8'd0, acc}, 16'd200);
        steps(3);
        check("add100_acc", {8'd0, acc}, 16'd44);
        check("add100_flags_zv", {14'd0, flag_z, flag_v}, 16'b01);
        steps(3);
        check("ldi80_keeps_flags", {8'd0, acc, 6'd0, flag_z, flag_v}, 16'h80_01 << 0);
        steps(3);
        check("mul_acc", {8'd0, acc}, 16'h00);
        check("mul_flags_zv", {14'd0, flag_z, flag_v}, 16'b11);
        steps(3);
        check("jnz_not_taken", {8'd0, rom_addr}, 16'h15);
        steps(3);
        check("ldi5a_acc", {8'd0, acc}, 16'h5A);

        // OUT with 4 cycles of backpressure
        steps(3);
        for (int i = 0; i < 4; i++) begin
            check("outw_valid", {15'd0, out_valid}, 16'd1);
            check("outw_data", {8'd0, out_data}, 16'h5A);
            step();
        end
        check("outw_valid_last", {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_done_valid", {15'd0, out_valid}, 16'd0);
        check("out_next_fetch", {8'd0, rom_addr}, 16'h17);
        steps(3);
        check("jmp07_addr", {8'd0, rom_addr}, 16'h07);

        // HALT and resume
        steps(3);
        check("halt_halted", {15'd0, halted}, 16'd1);
        check("halt_pc", {8'd0, rom_addr}, 16'h08);
        steps(2);
        check("halt_stays", {15'd0, halted}, 16'd1);
        run = 1'b1;
        step();
        run = 1'b0;
        check("resume_halted", {15'd0, halted}, 16'd0);
        check("resume_addr", {8'd0, rom_addr}, 16'h08);
        steps(3);
        check("ldi9_acc", {8'd0, acc}, 16'h09);

        // DIV by zero
        steps(3);
`ifdef ACC_SEQ_CTRL_DIVZ_TRAP_EN
        check("divz_trap", {15'd0, trap}, 16'd1);
        check("divz_halted", {15'd0, halted}, 16'd1);
        check("divz_acc", {8'd0, acc}, 16'h09);
        check("divz_flags_zv", {14'd0, flag_z, flag_v}, 16'b11);
        check("divz_pc", {8'd0, rom_addr}, 16'h0A);
        run = 1'b1;
        steps(2);
        run = 1'b0;
        check("divz_run_ignored", {15'd0, halted}, 16'd1);
        check("divz_trap_sticky", {15'd0, trap}, 16'd1);
`else
        check("divz_acc", {8'd0, acc}, 16'hFF);
        check("divz_flags_zv", {14'd0, flag_z, flag_v}, 16'b01);
        check("divz_trap_tied", {15'd0, trap}, 16'd0);
        check("divz_continues", {7'd0, halted, rom_addr}, 16'h0A);
        steps(3);
        check("jmpff_addr", {8'd0, rom_addr}, 16'hFF);
        steps(3);
        check("pc_wrap", {8'd0, rom_addr}, 16'h00);
`endif

        // Reset during OUTW
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_trap", {15'd0, trap}, 16'd0);
        run = 1'b1;
        step();
        run = 1'b0;
        steps(33);
        check("rerun_outw_valid", {15'd0, out_valid}, 16'd1);
        check("rerun_acc", {8'd0, acc}, 16'h5A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outw_valid", {15'd0, out_valid}, 16'd0);
        check("rst_outw_halted", {15'd0, halted}, 16'd1);
        check("rst_outw_pc", {8'd0, rom_addr}, 16'h00);
        check("rst_outw_acc", {8'd0, acc}, 16'h00);
        check("rst_outw_data", {8'd0, out_data}, 16'h00);
        step();
        check("rst_outw_stays_halted", {15'd0, halted}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
